// File: rtl/wbuf_feeder.sv
// Weight-buffer read feeder: pulls words from WBUF, splits them into lanes and
// drives the systolic array columns with a diagonal skew, one tile per start.
module wbuf_feeder #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [CNT_W-1:0]      tile_len,
  input  logic                  abort,
  input  logic                  wbuf_valid,
  input  logic [DATA_W-1:0]     wbuf_data,
  output logic                  wbuf_ready,
  output logic [DATA_W-1:0]     col_w,
  output logic [ARRAY_SIZE-1:0] col_valid,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned LANE_W = DATA_W / ARRAY_SIZE;
  localparam int unsigned DRN_W  = $clog2(ARRAY_SIZE + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(ARRAY_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_c;

  // A word is consumed only on a real handshake that abort does not override.
  assign accept_c = wbuf_valid & ready_q & ~abort;

  // Tile sequencing and registered control outputs.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (tile_len != '0) begin
            len_d   = tile_len;
            state_d = STREAM;
          end else begin
            state_d = DONE;
          end
        end
      end
      STREAM: begin
        if (accept_c) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == (len_q - CNT_ONE)) begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q + DRN_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      drn_d   = '0;
    end

    ready_d = (state_d == STREAM);
    busy_d  = (state_d == STREAM) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wbuf_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_cnt   = cnt_q;

  // Column c is a c+1 deep shift chain; idle cycles inject zero data with valid low.
  for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
    localparam int unsigned DEPTH = c + 1;
    localparam int unsigned SW    = DEPTH * LANE_W;

    logic [SW-1:0]    data_q, data_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    always_comb begin
      data_d = data_q << LANE_W;
      vld_d  = vld_q << 1;
      if (accept_c) begin
        data_d[LANE_W-1:0] = wbuf_data[c*LANE_W +: LANE_W];
        vld_d[0]           = 1'b1;
      end
      if (abort) begin
        data_d = '0;
        vld_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign col_w[c*LANE_W +: LANE_W] = data_q[SW-1 -: LANE_W];
    assign col_valid[c]              = vld_q[DEPTH-1];
  end

endmodule

// File: tb/tb_wbuf_feeder.sv
// Scoreboard bench for wbuf_feeder: stimulus pushes expected lane arrivals and
// done events; a negedge monitor pops and compares them against the DUT.
module tb_wbuf_feeder;

  localparam int unsigned AS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = DW / AS;
  localparam int BIG = 1000000;

  typedef struct {
    logic [LW-1:0] d;
    int            cyc;
  } lane_t;

  typedef struct {
    int            cyc;
    logic [CW-1:0] cnt;
  } done_t;

  logic          clk;
  logic          nRST;
  logic          start;
  logic [CW-1:0] tile_len;
  logic          abort;
  logic          wbuf_valid;
  logic [DW-1:0] wbuf_data;
  logic          wbuf_ready;
  logic [DW-1:0] col_w;
  logic [AS-1:0] col_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int s;

  lane_t exp_q[AS][$];
  done_t exp_done[$];

  wbuf_feeder #(.ARRAY_SIZE(AS), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .start     (start),
    .tile_len  (tile_len),
    .abort     (abort),
    .wbuf_valid(wbuf_valid),
    .wbuf_data (wbuf_data),
    .wbuf_ready(wbuf_ready),
    .col_w     (col_w),
    .col_valid (col_valid),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Lane c of a word transferred in cycle k is due on column c in cycle k+1+c.
  task automatic push_word(input logic [DW-1:0] w, input int k, input int lim);
    lane_t e;
    for (int c = 0; c < AS; c++) begin
      if (k + 1 + c <= lim) begin
        e.d   = w[c*LW +: LW];
        e.cyc = k + 1 + c;
        exp_q[c].push_back(e);
      end
    end
  endtask

  task automatic push_done(input int at, input logic [CW-1:0] cnt);
    done_t e;
    e.cyc = at;
    e.cnt = cnt;
    exp_done.push_back(e);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, 64'(wbuf_ready), 64'd0);
    chk({name, "_colw"},  64'(col_w),      64'd0);
    chk({name, "_colv"},  64'(col_valid),  64'd0);
    chk({name, "_busy"},  64'(busy),       64'd0);
    chk({name, "_done"},  64'(done),       64'd0);
    chk({name, "_cnt"},   64'(word_cnt),   64'd0);
  endtask

  // Monitor: compare lanes and done pulses against the scoreboard.
  always @(negedge clk) begin
    lane_t         e;
    done_t         de;
    logic [LW-1:0] lane;
    for (int c = 0; c < AS; c++) begin
      lane = col_w[c*LW +: LW];
      total++;
      if (col_valid[c]) begin
        if (exp_q[c].size() == 0) begin
          bad++;
          $display("FAIL col%0d unexpected valid cyc=%0d data=%0h", c, cyc, lane);
        end else begin
          e = exp_q[c].pop_front();
          if (e.d !== lane || e.cyc != cyc) begin
            bad++;
            $display("FAIL col%0d got data=%0h cyc=%0d want data=%0h cyc=%0d",
                     c, lane, cyc, e.d, e.cyc);
          end
        end
      end else begin
        if (lane !== '0) begin
          bad++;
          $display("FAIL col%0d bubble data got=%0h want=0 cyc=%0d", c, lane, cyc);
        end
        if (exp_q[c].size() != 0) begin
          total++;
          if (exp_q[c][0].cyc <= cyc) begin
            e = exp_q[c].pop_front();
            bad++;
            $display("FAIL col%0d missing lane data=%0h due cyc=%0d now=%0d", c, e.d, e.cyc, cyc);
          end
        end
      end
    end
    if (done) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL done unexpected pulse cyc=%0d", cyc);
      end else begin
        de = exp_done.pop_front();
        if (de.cyc != cyc || de.cnt !== word_cnt || busy !== 1'b0) begin
          bad++;
          $display("FAIL done got cyc=%0d cnt=%0d busy=%0b want cyc=%0d cnt=%0d busy=0",
                   cyc, word_cnt, busy, de.cyc, de.cnt);
        end
      end
    end else if (exp_done.size() != 0) begin
      total++;
      if (exp_done[0].cyc <= cyc) begin
        de = exp_done.pop_front();
        bad++;
        $display("FAIL done missing pulse due cyc=%0d now=%0d", de.cyc, cyc);
      end
    end
  end

  logic [DW-1:0] w3 [3];
  logic [DW-1:0] w4 [4];

  initial begin
    w3[0] = 32'h44332211; w3[1] = 32'h88776655; w3[2] = 32'hCCBBAA99;
    w4[0] = 32'h0D0C0B0A; w4[1] = 32'h1D1C1B1A; w4[2] = 32'h2D2C2B2A; w4[3] = 32'h3D3C3B3A;

    nRST = 1'b0; start = 1'b0; tile_len = '0; abort = 1'b0;
    wbuf_valid = 1'b0; wbuf_data = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    nRST = 1'b1;
    repeat (2) tick();

    // Three-word tile with valid held high throughout.
    start = 1'b1; tile_len = 8'd3; s = cyc;
    push_done(s + 8, 8'd3);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbuf_valid = 1'b1; wbuf_data = w3[i];
      push_word(w3[i], cyc, BIG);
      tick();
    end
    wbuf_data = 32'hDEADBEEF;
    repeat (2) tick();
    wbuf_valid = 1'b0;
    repeat (6) tick();
    chk("t1_hold_cnt", 64'(word_cnt), 64'd3);
    chk("t1_busy", 64'(busy), 64'd0);

    // Four-word tile with a one-cycle valid gap.
    start = 1'b1; tile_len = 8'd4; s = cyc;
    push_done(s + 10, 8'd4);
    tick();
    start = 1'b0;
    wbuf_valid = 1'b1; wbuf_data = w4[0]; push_word(w4[0], cyc, BIG); tick();
    chk("t2_busy", 64'(busy), 64'd1);
    wbuf_valid = 1'b0; wbuf_data = 32'h5A5A5A5A; tick();
    for (int i = 1; i < 4; i++) begin
      wbuf_valid = 1'b1; wbuf_data = w4[i];
      push_word(w4[i], cyc, BIG);
      tick();
    end
    wbuf_valid = 1'b0;
    repeat (8) tick();

    // Zero-length tile: done without any transfer.
    start = 1'b1; tile_len = 8'd0; s = cyc;
    wbuf_valid = 1'b1; wbuf_data = 32'h77777777;
    push_done(s + 1, 8'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready", 64'(wbuf_ready), 64'd0);
      chk("t3_colv", 64'(col_valid), 64'd0);
      tick();
    end
    wbuf_valid = 1'b0;
    repeat (2) tick();

    // Abort in the second drain cycle of a two-word tile.
    start = 1'b1; tile_len = 8'd2; s = cyc;
    tick();
    start = 1'b0;
    wbuf_valid = 1'b1; wbuf_data = 32'hA3A2A1A0; push_word(wbuf_data, cyc, s + 4); tick();
    wbuf_data = 32'hB3B2B1B0; push_word(wbuf_data, cyc, s + 4); tick();
    wbuf_data = 32'hEEEEEEEE; tick();
    abort = 1'b1; tick();
    abort = 1'b0; wbuf_valid = 1'b0;
    chk("t4_colv", 64'(col_valid), 64'd0);
    chk("t4_colw", 64'(col_w), 64'd0);
    chk("t4_cnt", 64'(word_cnt), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_ready", 64'(wbuf_ready), 64'd0);
    repeat (6) tick();

    // Start during STREAM with a different length is ignored.
    start = 1'b1; tile_len = 8'd3; s = cyc;
    push_done(s + 8, 8'd3);
    tick();
    start = 1'b0;
    wbuf_valid = 1'b1; wbuf_data = 32'h13121110; push_word(wbuf_data, cyc, BIG); tick();
    start = 1'b1; tile_len = 8'd7;
    wbuf_data = 32'h23222120; push_word(wbuf_data, cyc, BIG); tick();
    start = 1'b0;
    wbuf_data = 32'h33323130; push_word(wbuf_data, cyc, BIG); tick();
    wbuf_data = 32'h99999999;
    repeat (2) tick();
    wbuf_valid = 1'b0;
    repeat (6) tick();
    chk("t5_hold_cnt", 64'(word_cnt), 64'd3);

    // Reset after two of five words.
    start = 1'b1; tile_len = 8'd5; s = cyc;
    tick();
    start = 1'b0;
    wbuf_valid = 1'b1; wbuf_data = 32'h4B4A4948; push_word(wbuf_data, cyc, s + 2); tick();
    wbuf_data = 32'h5B5A5958; push_word(wbuf_data, cyc, s + 2); tick();
    chk("t6_busy_pre", 64'(busy), 64'd1);
    wbuf_valid = 1'b0;
    #1 nRST = 1'b0;
    #1 chk_all_zero("t6_rst");
    repeat (2) tick();
    nRST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_ready", 64'(wbuf_ready), 64'd0);
    end
    chk("t6_cnt", 64'(word_cnt), 64'd0);

    for (int c = 0; c < AS; c++) chk("left_lanes", 64'(exp_q[c].size()), 64'd0);
    chk("left_done", 64'(exp_done.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
